lsu_arbiter: RTL and testbench

LSU_ARBITER -- requirements
Module: lsu_arbiter

---
 rtl/lsu_arb_pkg.sv | 18 +
 rtl/lsu_byte_merge.sv | 16 +
 rtl/lsu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_lsu_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types for the LSU arbiter: FSM states, transaction owner and access kind.
package lsu_arb_pkg;

    typedef enum logic [1:0] {IDLE, RD_WAIT, MERGE_WR, RESP} state_e;
    typedef enum logic {OWN_CORE, OWN_DBG} owner_e;
    typedef enum logic [1:0] {OP_READ, OP_WR_FULL, OP_WR_PART, OP_WR_NONE} op_e;

    localparam logic [3:0] BMASK_FULL = 4'b1111;
    localparam logic [3:0] BMASK_NONE = 4'b0000;

    function automatic op_e core_op(input logic wren, input logic [3:0] bmask);
        if (!wren) return OP_READ;
        if (bmask == BMASK_FULL) return OP_WR_FULL;
        if (bmask == BMASK_NONE) return OP_WR_NONE;
        return OP_WR_PART;
    endfunction

endpackage

// File: rtl/lsu_byte_merge.sv
// Byte-lane merge for read-modify-write: enabled lanes come from the new word.
module lsu_byte_merge (
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_new_word,
    input  logic [3:0]  i_bmask,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_old_word;
        for (int b = 0; b < 4; b++) begin
            if (i_bmask[b]) o_merged[8*b +: 8] = i_new_word[8*b +: 8];
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Arbitrates core and debug accesses onto one word-wide memory port, with
// read-modify-write for partial core stores and bounded debug starvation.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int P_DBG_MAX_WAIT = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_core_req,
    input  logic        i_core_wren,
    input  logic [31:0] i_core_addr,
    input  logic [31:0] i_core_wdata,
    input  logic [3:0]  i_core_bmask,
    output logic        o_core_gnt,
    output logic        o_core_done,
    output logic [31:0] o_core_rdata,
    output logic        o_core_stall,
    input  logic        i_dbg_req,
    input  logic        i_dbg_wren,
    input  logic [31:0] i_dbg_addr,
    input  logic [31:0] i_dbg_wdata,
    output logic        o_dbg_gnt,
    output logic        o_dbg_done,
    output logic [31:0] o_dbg_rdata,
    output logic [29:0] o_mem_addr,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam int SW = $clog2(P_DBG_MAX_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(P_DBG_MAX_WAIT);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    op_e           op_q, op_d;
    logic [29:0]   addr_q, addr_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   rd_q;
    logic [31:0]   core_rdata_q;
    logic [31:0]   dbg_rdata_q;

    logic          core_gnt, dbg_gnt, mem_wren;
    logic [29:0]   mem_addr;
    logic [31:0]   mem_wdata, merged;

    logic          unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_core_addr[1:0], i_dbg_addr[1:0]};

    lsu_byte_merge u_merge (
        .i_old_word (rd_q),
        .i_new_word (wdata_q),
        .i_bmask    (mask_q),
        .o_merged   (merged)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        op_d      = op_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        starve_d  = starve_q;
        core_gnt  = 1'b0;
        dbg_gnt   = 1'b0;
        mem_addr  = '0;
        mem_wren  = 1'b0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (i_core_req && !(i_dbg_req && starve_q == STARVE_MAX)) begin
                    core_gnt = 1'b1;
                end else if (i_dbg_req) begin
                    dbg_gnt = 1'b1;
                end

                if (core_gnt) begin
                    owner_d = OWN_CORE;
                    op_d    = core_op(i_core_wren, i_core_bmask);
                    addr_d  = i_core_addr[31:2];
                    mask_d  = i_core_bmask;
                    wdata_d = i_core_wdata;
                    if (i_dbg_req && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
                end else if (dbg_gnt) begin
                    owner_d  = OWN_DBG;
                    op_d     = i_dbg_wren ? OP_WR_FULL : OP_READ;
                    addr_d   = i_dbg_addr[31:2];
                    mask_d   = BMASK_FULL;
                    wdata_d  = i_dbg_wdata;
                    starve_d = '0;
                end
                if (!i_dbg_req) starve_d = '0;

                if (core_gnt || dbg_gnt) begin
                    // Partial stores read the old word first, exactly like a load.
                    state_d = (op_d == OP_READ || op_d == OP_WR_PART) ? RD_WAIT : RESP;
                    if (op_d != OP_WR_NONE) mem_addr = addr_d;
                    if (op_d == OP_WR_FULL) begin
                        mem_wren  = 1'b1;
                        mem_wdata = wdata_d;
                    end
                end
            end
            RD_WAIT: state_d = (op_q == OP_WR_PART) ? MERGE_WR : RESP;
            MERGE_WR: begin
                mem_addr  = addr_q;
                mem_wren  = 1'b1;
                mem_wdata = merged;
                state_d   = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CORE;
            op_q         <= OP_READ;
            addr_q       <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            starve_q     <= '0;
            rd_q         <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            if (state_q == RD_WAIT) begin
                rd_q <= i_mem_rdata;
                if (op_q == OP_READ && owner_q == OWN_CORE) core_rdata_q <= i_mem_rdata;
                if (op_q == OP_READ && owner_q == OWN_DBG)  dbg_rdata_q  <= i_mem_rdata;
            end
        end
    end

    // Grant and memory strobes decode straight from requests in IDLE, so hold them off during reset.
    assign o_core_gnt   = core_gnt & i_rst_n;
    assign o_dbg_gnt    = dbg_gnt & i_rst_n;
    assign o_mem_wren   = mem_wren & i_rst_n;
    assign o_mem_addr   = i_rst_n ? mem_addr : '0;
    assign o_mem_wdata  = i_rst_n ? mem_wdata : '0;

    assign o_core_done  = (state_q == RESP) && (owner_q == OWN_CORE);
    assign o_dbg_done   = (state_q == RESP) && (owner_q == OWN_DBG);
    assign o_core_rdata = core_rdata_q;
    assign o_dbg_rdata  = dbg_rdata_q;
    assign o_core_stall = i_core_req & ~o_core_done;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter: vector table with scoreboard plus
// hand-written arbitration, debug and reset sequences.
module tb_lsu_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_core_req, i_core_wren;
    logic [31:0] i_core_addr, i_core_wdata;
    logic [3:0]  i_core_bmask;
    logic        o_core_gnt, o_core_done, o_core_stall;
    logic [31:0] o_core_rdata;
    logic        i_dbg_req, i_dbg_wren;
    logic [31:0] i_dbg_addr, i_dbg_wdata;
    logic        o_dbg_gnt, o_dbg_done;
    logic [31:0] o_dbg_rdata;
    logic [29:0] o_mem_addr;
    logic        o_mem_wren;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    always #5 i_clk = ~i_clk;

    lsu_arbiter #(.P_DBG_MAX_WAIT(3)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_core_req   (i_core_req),
        .i_core_wren  (i_core_wren),
        .i_core_addr  (i_core_addr),
        .i_core_wdata (i_core_wdata),
        .i_core_bmask (i_core_bmask),
        .o_core_gnt   (o_core_gnt),
        .o_core_done  (o_core_done),
        .o_core_rdata (o_core_rdata),
        .o_core_stall (o_core_stall),
        .i_dbg_req    (i_dbg_req),
        .i_dbg_wren   (i_dbg_wren),
        .i_dbg_addr   (i_dbg_addr),
        .i_dbg_wdata  (i_dbg_wdata),
        .o_dbg_gnt    (o_dbg_gnt),
        .o_dbg_done   (o_dbg_done),
        .o_dbg_rdata  (o_dbg_rdata),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wren   (o_mem_wren),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata)
    );

    // Memory model: data one cycle after address, writes land on the clock edge.
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge i_clk) begin
        i_mem_rdata <= mem[o_mem_addr[7:0]];
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (o_mem_wren) mem[o_mem_addr[7:0]] <= o_mem_wdata;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [29:0] waddr, input logic [31:0] data);
        @(negedge i_clk);
        pre_en   = 1'b1;
        pre_addr = waddr[7:0];
        pre_data = data;
        @(negedge i_clk);
        pre_en   = 1'b0;
    endtask

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic [31:0] pre;
        logic [29:0] exp_maddr;
        int          exp_lat;
        int          exp_wr_cyc;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        int          lat;
        logic        is_read;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs [7];
    exp_t sb [$];

    initial begin
        int         k, wr_cnt, wr_cyc, gnt_cnt, bad;
        logic       done;
        exp_t       e;
        int         g [8];
        int         n;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 30'h4,  2, -1, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 32'h1122_3344, 30'h8,  3,  2, 32'h1122_AB44};
        vecs[2] = '{1'b1, 32'h0000_0030, 32'h1234_5678, 4'b1111, 32'h0,         30'hC,  1,  0, 32'h1234_5678};
        vecs[3] = '{1'b1, 32'h0000_0034, 32'hFFFF_FFFF, 4'b0000, 32'hA5A5_A5A5, 30'h0,  1, -1, 32'hA5A5_A5A5};
        vecs[4] = '{1'b1, 32'h0000_0044, 32'hFF00_00EE, 4'b1001, 32'h1122_3344, 30'h11, 3,  2, 32'hFF22_33EE};
        vecs[5] = '{1'b0, 32'h0000_0103, 32'h0,         4'b0000, 32'h0BAD_F00D, 30'h40, 2, -1, 32'h0BAD_F00D};
        vecs[6] = '{1'b1, 32'h0000_0048, 32'h00CD_0000, 4'b0100, 32'h0,         30'h12, 3,  2, 32'h00CD_0000};

        i_rst_n = 1'b0;
        i_core_req = 0; i_core_wren = 0; i_core_addr = '0; i_core_wdata = '0; i_core_bmask = '0;
        i_dbg_req = 0; i_dbg_wren = 0; i_dbg_addr = '0; i_dbg_wdata = '0;
        #12;
        chk("rst_core_gnt", {31'b0, o_core_gnt}, 32'h0);
        chk("rst_dbg_gnt", {31'b0, o_dbg_gnt}, 32'h0);
        chk("rst_done", {30'b0, o_core_done, o_dbg_done}, 32'h0);
        chk("rst_mem_wren", {31'b0, o_mem_wren}, 32'h0);
        chk("rst_core_rdata", o_core_rdata, 32'h0);
        chk("rst_dbg_rdata", o_dbg_rdata, 32'h0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // Core-only transactions from the table.
        foreach (vecs[i]) begin
            preload(vecs[i].addr[31:2], vecs[i].pre);
            @(negedge i_clk);
            i_core_req   = 1'b1;
            i_core_wren  = vecs[i].wren;
            i_core_addr  = vecs[i].addr;
            i_core_wdata = vecs[i].wdata;
            i_core_bmask = vecs[i].bmask;
            sb.push_back('{vecs[i].exp_lat, !vecs[i].wren, vecs[i].pre});
            #1;
            chk($sformatf("v%0d_gnt", i), {31'b0, o_core_gnt}, 32'h1);
            chk($sformatf("v%0d_maddr", i), {2'b0, o_mem_addr}, {2'b0, vecs[i].exp_maddr});
            chk($sformatf("v%0d_stall_T", i), {31'b0, o_core_stall}, 32'h1);
            k = 0; wr_cnt = 0; wr_cyc = -1; gnt_cnt = 0; done = 1'b0;
            while (!done && k < 8) begin
                if (o_core_gnt) gnt_cnt++;
                if (o_mem_wren) begin
                    wr_cnt++;
                    wr_cyc = k;
                    chk($sformatf("v%0d_wr_addr", i), {2'b0, o_mem_addr}, {2'b0, vecs[i].addr[31:2]});
                    chk($sformatf("v%0d_wr_data", i), o_mem_wdata, vecs[i].exp_word);
                end
                if (o_core_done) begin
                    done = 1'b1;
                    e = sb.pop_front();
                    chk($sformatf("v%0d_latency", i), k, e.lat);
                    if (e.is_read) chk($sformatf("v%0d_rdata", i), o_core_rdata, e.rdata);
                    chk($sformatf("v%0d_stall_done", i), {31'b0, o_core_stall}, 32'h0);
                end else begin
                    @(negedge i_clk);
                    #1;
                    k++;
                end
            end
            chk($sformatf("v%0d_done_seen", i), {31'b0, done}, 32'h1);
            i_core_req = 1'b0;
            chk($sformatf("v%0d_gnt_pulses", i), gnt_cnt, 1);
            chk($sformatf("v%0d_wr_count", i), wr_cnt, (vecs[i].exp_wr_cyc >= 0) ? 1 : 0);
            chk($sformatf("v%0d_wr_cycle", i), wr_cyc, vecs[i].exp_wr_cyc);
            chk($sformatf("v%0d_mem_word", i), mem[vecs[i].addr[9:2]], vecs[i].exp_word);
        end

        // Debug full-word write alone, then read it back.
        @(negedge i_clk);
        i_dbg_req = 1'b1; i_dbg_wren = 1'b1; i_dbg_addr = 32'h40; i_dbg_wdata = 32'hCAFE_0001;
        #1;
        chk("dbgw_gnt", {31'b0, o_dbg_gnt}, 32'h1);
        chk("dbgw_core_gnt", {31'b0, o_core_gnt}, 32'h0);
        chk("dbgw_wren", {31'b0, o_mem_wren}, 32'h1);
        chk("dbgw_addr", {2'b0, o_mem_addr}, 32'h10);
        chk("dbgw_wdata", o_mem_wdata, 32'hCAFE_0001);
        chk("dbgw_stall", {31'b0, o_core_stall}, 32'h0);
        @(negedge i_clk); #1;
        chk("dbgw_done", {31'b0, o_dbg_done}, 32'h1);
        chk("dbgw_core_done", {31'b0, o_core_done}, 32'h0);
        chk("dbgw_wren_T1", {31'b0, o_mem_wren}, 32'h0);
        chk("dbgw_mem", mem[8'h10], 32'hCAFE_0001);
        i_dbg_req = 1'b0;
        @(negedge i_clk);
        i_dbg_req = 1'b1; i_dbg_wren = 1'b0;
        #1;
        chk("dbgr_gnt", {31'b0, o_dbg_gnt}, 32'h1);
        @(negedge i_clk); #1;
        chk("dbgr_done_T1", {31'b0, o_dbg_done}, 32'h0);
        @(negedge i_clk); #1;
        chk("dbgr_done_T2", {31'b0, o_dbg_done}, 32'h1);
        chk("dbgr_rdata", o_dbg_rdata, 32'hCAFE_0001);
        i_dbg_req = 1'b0;

        // Both requesting continuously: debug gets every fourth grant.
        @(negedge i_clk);
        i_core_req = 1'b1; i_core_wren = 1'b0; i_core_addr = 32'h0;
        i_dbg_req = 1'b1; i_dbg_wren = 1'b0; i_dbg_addr = 32'h4;
        n = 0; bad = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            #1;
            if (o_core_gnt && o_dbg_gnt) bad++;
            if (o_core_gnt) g[n++] = 0;
            else if (o_dbg_gnt) begin
                g[n++] = 1;
                chk("arb_stall_waiting", {31'b0, o_core_stall}, 32'h1);
            end
            @(negedge i_clk);
        end
        chk("arb_grant_count", n, 8);
        chk("arb_dual_grant", bad, 0);
        for (int i = 0; i < n; i++) chk($sformatf("arb_order%0d", i), g[i], (i % 4 == 3) ? 1 : 0);
        i_core_req = 1'b0; i_dbg_req = 1'b0;
        repeat (4) @(negedge i_clk);

        // Reset while a core read sits in RD_WAIT.
        preload(30'h14, 32'h0000_0077);
        @(negedge i_clk);
        i_core_req = 1'b1; i_core_wren = 1'b0; i_core_addr = 32'h50;
        #1;
        chk("rst_mid_gnt", {31'b0, o_core_gnt}, 32'h1);
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b0; i_core_req = 1'b0;
        #1;
        chk("rst_mid_outs", {26'b0, o_core_gnt, o_dbg_gnt, o_core_done, o_dbg_done, o_mem_wren, o_core_stall}, 32'h0);
        chk("rst_mid_maddr", {2'b0, o_mem_addr}, 32'h0);
        chk("rst_mid_wdata", o_mem_wdata, 32'h0);
        chk("rst_mid_core_rdata", o_core_rdata, 32'h0);
        chk("rst_mid_dbg_rdata", o_dbg_rdata, 32'h0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (o_core_done || o_mem_wren) bad++;
            @(negedge i_clk);
        end
        chk("rst_no_resume", bad, 0);
        i_dbg_req = 1'b1; i_dbg_wren = 1'b0; i_dbg_addr = 32'h50;
        #1;
        chk("rst_idle_gnt", {31'b0, o_dbg_gnt}, 32'h1);
        @(negedge i_clk);
        @(negedge i_clk); #1;
        chk("rst_dbg_done", {31'b0, o_dbg_done}, 32'h1);
        chk("rst_dbg_rdata", o_dbg_rdata, 32'h0000_0077);
        i_dbg_req = 1'b0;
        repeat (2) @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
